// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/condition encodings and flag-write classification for the 16-bit CPU
// Contents: opcode_t (4-bit ISA opcodes), cond_t (3-bit branch condition codes),
//           writes_flags() returning {all, z_only} for an opcode.
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;
  typedef enum logic [2:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cond_t;
  // Bit 1: opcode writes Z, V and N; bit 0: opcode writes Z alone.
  function automatic logic [1:0] writes_flags(opcode_t op);
    return {op inside {OP_ADD, OP_SUB}, op inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR}};
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition resolver against the registered flags
// Ports: i_cond (ccc field), i_zf/i_vf/i_nf (architectural flags), o_taken (condition holds)
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_zf,
  input  logic       i_vf,
  input  logic       i_nf,
  output logic       o_taken
);
  cond_t w_cond;
  assign w_cond = cond_t'(i_cond);
  always_comb begin
    o_taken = 1'b0;
    case (w_cond)
      CC_NE:     o_taken = !i_zf;
      CC_EQ:     o_taken = i_zf;
      CC_GT:     o_taken = !i_zf && !i_nf;
      CC_LT:     o_taken = i_nf;
      CC_GTE:    o_taken = i_zf || !i_nf;
      CC_LTE:    o_taken = i_nf || i_zf;
      CC_OVFL:   o_taken = i_vf;
      CC_UNCOND: o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/V/N flags, branch resolution in ID and flag-hazard stall
// Ports: clk, rst_n (sync active-low); EX_valid/EX_Opcode/Z_set/V_set/N_set from the EX stage;
//        ID_valid/ID_Opcode/ID_cond/ID_imm9/ID_PC_next/ID_reg_target from the ID stage;
//        ZF/VF/NF registered flags; Flag_stall, Branch_taken, Branch_target to fetch/pipeline control.
module flag_branch_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_valid,
  input  logic [3:0]  EX_Opcode,
  input  logic        Z_set,
  input  logic        V_set,
  input  logic        N_set,
  input  logic        ID_valid,
  input  logic [3:0]  ID_Opcode,
  input  logic [2:0]  ID_cond,
  input  logic [8:0]  ID_imm9,
  input  logic [15:0] ID_PC_next,
  input  logic [15:0] ID_reg_target,
  output logic        ZF,
  output logic        VF,
  output logic        NF,
  output logic        Flag_stall,
  output logic        Branch_taken,
  output logic [15:0] Branch_target
);
  logic        r_zf, r_vf, r_nf;
  logic [1:0]  w_wr;
  logic        w_ex_wr, w_id_br, w_cond_true;
  logic [15:0] w_b_target;
  assign w_wr = writes_flags(opcode_t'(EX_Opcode));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zf <= 1'b0;
      r_vf <= 1'b0;
      r_nf <= 1'b0;
    end else if (EX_valid) begin
      if (|w_wr) r_zf <= Z_set;
      if (w_wr[1]) begin
        r_vf <= V_set;
        r_nf <= N_set;
      end
    end
  end
  branch_cond_eval u_cond (
    .i_cond (ID_cond),
    .i_zf   (r_zf),
    .i_vf   (r_vf),
    .i_nf   (r_nf),
    .o_taken(w_cond_true)
  );
  // Conditions read only the registered flags, so any flag writer in EX must retire first.
  assign w_ex_wr    = EX_valid && |w_wr;
  assign w_id_br    = ID_valid && (opcode_t'(ID_Opcode) inside {OP_B, OP_BR});
  assign w_b_target = ID_PC_next + {{6{ID_imm9[8]}}, ID_imm9, 1'b0};
  assign ZF            = r_zf;
  assign VF            = r_vf;
  assign NF            = r_nf;
  assign Flag_stall    = rst_n && w_id_br && w_ex_wr;
  assign Branch_taken  = rst_n && w_id_br && !w_ex_wr && w_cond_true;
  assign Branch_target = !rst_n ? 16'h0000 : (opcode_t'(ID_Opcode) == OP_BR ? ID_reg_target : w_b_target);
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed plus randomized checking of flag_branch_unit against a behavioural model
module tb_flag_branch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EX_valid = 1'b0;
  logic [3:0]  EX_Opcode = 4'h0;
  logic        Z_set = 1'b0, V_set = 1'b0, N_set = 1'b0;
  logic        ID_valid = 1'b0;
  logic [3:0]  ID_Opcode = 4'h0;
  logic [2:0]  ID_cond = 3'd0;
  logic [8:0]  ID_imm9 = 9'd0;
  logic [15:0] ID_PC_next = 16'h0;
  logic [15:0] ID_reg_target = 16'h0;
  logic        ZF, VF, NF, Flag_stall, Branch_taken;
  logic [15:0] Branch_target;
  int checks = 0;
  int failures = 0;
  bit started = 0;
  logic mz, mv, mn;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_Opcode(EX_Opcode),
    .Z_set(Z_set), .V_set(V_set), .N_set(N_set), .ID_valid(ID_valid),
    .ID_Opcode(ID_Opcode), .ID_cond(ID_cond), .ID_imm9(ID_imm9),
    .ID_PC_next(ID_PC_next), .ID_reg_target(ID_reg_target),
    .ZF(ZF), .VF(VF), .NF(NF), .Flag_stall(Flag_stall),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(input logic [2:0] c, input logic z, input logic v, input logic n);
    case (c)
      3'd0: return z == 0;
      3'd1: return z == 1;
      3'd2: return z == 0 && n == 0;
      3'd3: return n == 1;
      3'd4: return z == 1 || (z == 0 && n == 0);
      3'd5: return n == 1 || z == 1;
      3'd6: return v == 1;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model flags: architectural effect of each retired EX instruction.
  always @(posedge clk) begin
    if (!rst_n) begin
      mz <= 0; mv <= 0; mn <= 0;
    end else if (EX_valid && EX_Opcode inside {4'h0, 4'h1}) begin
      mz <= Z_set; mv <= V_set; mn <= N_set;
    end else if (EX_valid && EX_Opcode inside {4'h2, 4'h4, 4'h5, 4'h6}) begin
      mz <= Z_set;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit br, exw, e_stall, e_taken;
      logic [15:0] e_tgt;
      br = ID_valid && (ID_Opcode == 4'hC || ID_Opcode == 4'hD);
      exw = EX_valid && (EX_Opcode inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
      e_stall = rst_n && br && exw;
      e_taken = rst_n && br && !exw && cond_true(ID_cond, mz, mv, mn);
      e_tgt = (ID_Opcode == 4'hD) ? ID_reg_target
            : 16'(int'(ID_PC_next) + int'($signed(ID_imm9)) * 2);
      if (!rst_n) e_tgt = 16'h0;
      chk("m_flags", {13'd0, ZF, VF, NF}, {13'd0, mz, mv, mn});
      chk("m_stall", {15'd0, Flag_stall}, {15'd0, e_stall});
      chk("m_taken", {15'd0, Branch_taken}, {15'd0, e_taken});
      if (e_taken || !rst_n) chk("m_target", Branch_target, e_tgt);
      else chk("m_target_known", {15'd0, $isunknown(Branch_target)}, 16'd0);
    end
  end

  task automatic go(input logic r, input logic exv, input logic [3:0] exop,
                    input logic z, input logic v, input logic n,
                    input logic idv, input logic [3:0] idop, input logic [2:0] c,
                    input logic [8:0] imm, input logic [15:0] pc, input logic [15:0] rt);
    @(posedge clk); #1;
    rst_n = r; EX_valid = exv; EX_Opcode = exop; Z_set = z; V_set = v; N_set = n;
    ID_valid = idv; ID_Opcode = idop; ID_cond = c; ID_imm9 = imm; ID_PC_next = pc; ID_reg_target = rt;
    started = 1;
    @(negedge clk);
  endtask

  initial begin
    go(0, 0, 4'h0, 0, 0, 0, 1, 4'hC, 3'd7, 9'd5, 16'h100, 16'h0);
    chk("rst_flags", {13'd0, ZF, VF, NF}, 16'd0);
    chk("rst_taken", {15'd0, Branch_taken}, 16'd0);
    chk("rst_target", Branch_target, 16'h0);
    go(1, 1, 4'h0, 0, 1, 1, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    go(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    chk("add_flags", {13'd0, ZF, VF, NF}, 16'b011);
    go(0, 1, 4'h1, 1, 0, 0, 1, 4'hC, 3'd1, 9'd0, 16'h0, 16'h0);
    chk("rst_stall", {14'd0, Flag_stall, Branch_taken}, 16'd0);
    go(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    chk("rst_clear", {13'd0, ZF, VF, NF}, 16'd0);
    go(1, 1, 4'h0, 0, 1, 1, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    go(1, 1, 4'h2, 1, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    go(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    chk("xor_flags", {13'd0, ZF, VF, NF}, 16'b111);
    go(1, 1, 4'h0, 0, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    go(1, 1, 4'h1, 1, 0, 0, 1, 4'hC, 3'd1, 9'd4, 16'h20, 16'h0);
    chk("haz_stall", {14'd0, Flag_stall, Branch_taken}, 16'b10);
    go(1, 0, 4'h1, 0, 0, 0, 1, 4'hC, 3'd1, 9'd4, 16'h20, 16'h0);
    chk("haz_resolve", {14'd0, Flag_stall, Branch_taken}, 16'b01);
    chk("haz_target", Branch_target, 16'h0028);
    go(1, 0, 4'h0, 0, 0, 0, 1, 4'hC, 3'd7, 9'h1FE, 16'h0010, 16'h0);
    chk("b_neg_taken", {15'd0, Branch_taken}, 16'd1);
    chk("b_neg_target", Branch_target, 16'h000C);
    go(1, 0, 4'h0, 0, 0, 0, 1, 4'hC, 3'd7, 9'h001, 16'hFFFE, 16'h0);
    chk("b_wrap_target", Branch_target, 16'h0000);
    go(1, 0, 4'h0, 0, 0, 0, 1, 4'hD, 3'd7, 9'h0, 16'h0, 16'h1234);
    chk("br_target", Branch_target, 16'h1234);
    go(1, 1, 4'h0, 1, 0, 1, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    go(1, 1, 4'h8, 0, 1, 0, 1, 4'hD, 3'd0, 9'd0, 16'h0, 16'h4444);
    chk("lw_no_stall", {15'd0, Flag_stall}, 16'd0);
    go(1, 0, 4'h8, 0, 1, 0, 1, 4'hC, 3'd0, 9'd0, 16'h0, 16'h0);
    chk("lw_flags", {13'd0, ZF, VF, NF}, 16'b101);
    go(1, 0, 4'h0, 0, 1, 0, 1, 4'hC, 3'd1, 9'd0, 16'h0, 16'h0);
    chk("exv0_no_stall", {14'd0, Flag_stall, Branch_taken}, 16'b01);
    go(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
    chk("exv0_flags", {13'd0, ZF, VF, NF}, 16'b101);
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++) begin
        go(1, 1, 4'h0, f[2], f[1], f[0], 0, 4'h0, 3'd0, 9'd0, 16'h0, 16'h0);
        go(1, 0, 4'h1, 0, 0, 0, 1, 4'hC, 3'(c), 9'($urandom), 16'($urandom), 16'h0);
      end
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] idop;
      idop = $urandom_range(0, 1) ? 4'($urandom_range(12, 13)) : 4'($urandom);
      go($urandom_range(0, 31) != 0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom_range(0, 3) != 0), idop, 3'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
